guess_input: RTL and testbench

Player-side input conditioner for the LED guessing game. It synchronizes and debounces the four raw push-buttons and presents each debounced press to the game FSM exactly once, as a clean one-hot guess code on `b`. Each press is reported by a one-cycle `b_valid` strobe, with a flag when more than one button is down. It sits between the board button pins and the game FSM's `b` input.

---
 rtl/guess_input.sv | 90 +++++++++
 tb/tb_guess_input.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_input.sv
// Button input conditioner: 2-flop sync, shared whole-vector debounce, one strobe per press.
// Define GUESS_INPUT_HOLD_EN to hold b at the captured code for the whole press instead of a one-cycle pulse.
module guess_input #(
  parameter int DB_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] b,
  output logic       b_valid,
  output logic       multi,
  output logic       busy
);

  localparam logic [DB_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, HELD} state_t;

  state_t          state_q;
  logic [3:0]      meta_q, sync_q, cand_q, stable_q, pat_q;
  logic [DB_W-1:0] cnt_q;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_bit(input logic [3:0] p);
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 4'd0;
      sync_q   <= 4'd0;
      cand_q   <= 4'd0;
      stable_q <= 4'd0;
      cnt_q    <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != MAX) begin
        cnt_q <= cnt_q + DB_W'(1);
        if (cnt_q == MAX - DB_W'(1)) stable_q <= cand_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= 4'd0;
      b       <= 4'd0;
      b_valid <= 1'b0;
      multi   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      b_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stable_q != 4'd0) begin
            state_q <= CAPTURE;
            pat_q   <= stable_q;
            b       <= stable_q;
            b_valid <= 1'b1;
            multi   <= multi_bit(stable_q);
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          state_q <= HELD;
`ifdef GUESS_INPUT_HOLD_EN
          b <= pat_q;
`else
          b <= 4'd0;
`endif
        end
        HELD: begin
          // Partial releases or added buttons are ignored until everything is up.
          if (stable_q == 4'd0) begin
            state_q <= IDLE;
            b       <= 4'd0;
            busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_input.sv
// Scoreboard bench for guess_input with DB_W=2: a sample-history reference model predicts
// strobes into a queue, and a negedge monitor pops and compares whenever the DUT responds.
module tb_guess_input;

  localparam int DB_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'd0;
  logic [3:0] b;
  logic       b_valid, multi, busy;

  always #5 clk = ~clk;

  guess_input #(.DB_W(DB_W)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .b(b), .b_valid(b_valid), .multi(multi), .busy(busy)
  );

  typedef struct packed {logic [3:0] code; logic mb;} exp_t;
  exp_t expq[$];

  int errors = 0;
  int checks = 0;
  int strobes = 0;

  // Reference model state: raw samples per edge, debounced value, press status.
  logic [3:0] hist [6];
  logic [3:0] m_stable, m_pat;
  bit         m_busy, m_multi;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Debounced value changes only once the raw input has read the same for MAX+1 samples,
  // seen two synchronizer stages late; a press is reported once and cleared by full release.
  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 6; i++) hist[i] = 4'd0;
        m_stable = 4'd0; m_pat = 4'd0; m_busy = 0; m_multi = 0;
        expq.delete();
      end else begin
        if (!m_busy && m_stable != 4'd0) begin
          m_busy  = 1;
          m_pat   = m_stable;
          m_multi = ($countones(m_stable) > 1);
          expq.push_back('{code: m_stable, mb: m_multi});
        end else if (m_busy && m_stable == 4'd0) begin
          m_busy = 0;
        end
        for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn_raw;
        if (hist[2] == hist[3] && hist[3] == hist[4] && hist[4] == hist[5])
          m_stable = hist[2];
      end
    end
  end

  initial begin : monitor
    bit exp_strobe;
    exp_t e;
    forever begin
      @(negedge clk);
      exp_strobe = (expq.size() > 0);
      if (b_valid) begin
        strobes++;
        if (!exp_strobe) chk("spurious_strobe", 1, 0);
        else begin
          e = expq.pop_front();
          chk("strobe_b", int'(b), int'(e.code));
          chk("strobe_multi", int'(multi), int'(e.mb));
        end
      end else if (exp_strobe) begin
        void'(expq.pop_front());
        chk("missing_strobe", 0, 1);
      end
      chk("busy", int'(busy), int'(m_busy));
      chk("multi_held", int'(multi), int'(m_multi));
`ifdef GUESS_INPUT_HOLD_EN
      chk("b_hold", int'(b), m_busy ? int'(m_pat) : 0);
`else
      chk("b_pulse", int'(b), exp_strobe ? int'(m_pat) : 0);
`endif
    end
  end

  // Advance n edges, leaving inputs to change 3 time units after the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Edges until b_valid is seen (sampled just after each edge); -1 if the budget runs out.
  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (b_valid) begin n = i; break; end
    end
    #2;
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (!busy) begin n = i; break; end
    end
    #2;
  endtask

  initial begin : stim
    int n, s0;
    cyc(3);
    chk("rst_b", int'(b), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(10);

    // Clean press
    s0 = strobes;
    btn_raw = 4'b0100;
    wait_strobe(n);
    chk("clean_latency", n, 7);
    chk("clean_b", int'(b), 4'b0100);
    chk("clean_multi", int'(multi), 0);
    cyc(13);
    btn_raw = 4'd0;
    wait_idle(n);
    chk("clean_release", n, 7);
    cyc(5);
    chk("clean_count", strobes - s0, 1);

    // Bounce then settle
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      cyc(2);
    end
    chk("bounce_none", strobes - s0, 0);
    btn_raw = 4'b0001;
    wait_strobe(n);
    chk("bounce_latency", n, 7);
    cyc(5);
    btn_raw = 4'd0;
    cyc(12);
    chk("bounce_count", strobes - s0, 1);

    // Multi then single
    btn_raw = 4'b1001;
    wait_strobe(n);
    chk("multi_b", int'(b), 4'b1001);
    chk("multi_flag", int'(multi), 1);
    cyc(4); btn_raw = 4'd0; cyc(12);
    btn_raw = 4'b0001;
    wait_strobe(n);
    chk("single_flag", int'(multi), 0);
    cyc(4); btn_raw = 4'd0; cyc(12);

    // Change while held
    s0 = strobes;
    btn_raw = 4'b0001; cyc(10);
    btn_raw = 4'b0011; cyc(10);
    btn_raw = 4'b0010; cyc(10);
    chk("held_busy", int'(busy), 1);
    btn_raw = 4'd0;
    wait_idle(n);
    chk("held_release", n, 7);
    cyc(5);
    chk("held_count", strobes - s0, 1);

    // Repeat presses
    s0 = strobes;
    for (int k = 0; k < 2; k++) begin
      btn_raw = 4'b1000; cyc(10);
      btn_raw = 4'd0;    cyc(10);
    end
    chk("repeat_count", strobes - s0, 2);

    // Random presses, glitches and partial releases
    for (int k = 0; k < 60; k++) begin
      btn_raw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc($urandom_range(1, 14));
    end
    btn_raw = 4'd0;
    cyc(15);

    // Reset mid-press, button still held afterwards
    btn_raw = 4'b0010;
    wait_strobe(n);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("midrst_b", int'(b), 0);
    chk("midrst_valid", int'(b_valid), 0);
    chk("midrst_multi", int'(multi), 0);
    chk("midrst_busy", int'(busy), 0);
    cyc(3);
    rst = 1'b0;
    wait_strobe(n);
    chk("rerst_latency", n, 7);
    chk("rerst_b", int'(b), 4'b0010);
    cyc(3);
    btn_raw = 4'd0;
    cyc(15);

    chk("pending_expect", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
